// File: rtl/serial_add_ctrl.sv
// Serial LSB-first adder sequencer around an external full adder. Result valid WIDTH+1 cycles after accept.
// Input accepted only in IDLE; result held stable in DONE until out_ready_i, so downstream may stall indefinitely.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             a_out_o,
  output logic             b_out_o,
  output logic             carry_o,
  input  logic             fa_sum_i,
  input  logic             fa_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    cout_d      = cout_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    a_out_o     = 1'b0;
    b_out_o     = 1'b0;
    carry_o     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_out_o  = a_sh_q[0];
        b_out_o  = b_sh_q[0];
        carry_o  = carry_q;
        sum_sh_d = {fa_sum_i, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry_i;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Result copy is taken on the final bit so sum_o/cout_o never move outside DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = sum_sh_d;
          cout_d  = fa_carry_i;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_o  = res_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table, corner-case sequences and random ops against an arithmetic model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         a_out, b_out, carry;
  logic         fa_sum, fa_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] atr, btr, ctr;

  always #5 clk = ~clk;

  // External full adder closing the loop.
  assign fa_sum   = a_out ^ b_out ^ carry;
  assign fa_carry = (a_out & b_out) | (a_out & carry) | (b_out & carry);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin),
    .a_out_o(a_out), .b_out_o(b_out), .carry_o(carry),
    .fa_sum_i(fa_sum), .fa_carry_i(fa_carry),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .cout_o(cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Carry into bit i is bit i of the sum of the operands truncated to their low i bits.
  function automatic logic [W-1:0] carry_in_trace(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic c);
    logic [W-1:0] t;
    int m, s;
    for (int i = 0; i < W; i++) begin
      m = (1 << i) - 1;
      s = (int'(x) & m) + (int'(y) & m) + int'(c);
      t[i] = s[i];
    end
    return t;
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is seen (lat cycles after accept).
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       output int lat);
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (lat <= W) begin
        atr[lat-1] = a_out;
        btr[lat-1] = b_out;
        ctr[lat-1] = carry;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[8];
  int lat;
  logic [W:0] exp9;
  bit seen;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_bits", {a_out, b_out, carry}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("v%0d_latency", i), lat, W + 1);
      check($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("v%0d_cout", i), cout, vecs[i].exp_cout);
      check($sformatf("v%0d_a_bits", i), atr, vecs[i].a);
      check($sformatf("v%0d_b_bits", i), btr, vecs[i].b);
      check($sformatf("v%0d_carry_bits", i), ctr,
            carry_in_trace(vecs[i].a, vecs[i].b, vecs[i].cin));
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), {in_ready, out_valid}, 2'b10);
    end
    // Spec sequences spelled out for the first and carry-in-only cases.
    do_op(8'h05, 8'h03, 1'b0, lat);
    check("basic_a_seq", atr, 8'b0000_0101);
    @(negedge clk);
    do_op(8'h00, 8'h00, 1'b1, lat);
    check("cin_only_carry_seq", ctr, 8'b0000_0001);
    @(negedge clk);

    // Backpressure: result must hold for 5 stalled cycles.
    out_ready = 1'b0;
    do_op(8'h3C, 8'h0F, 1'b1, lat);
    check("bp_latency", lat, W + 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k), {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h4C});
      @(negedge clk);
    end
    check("bp_hold_last", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h4C});
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {in_ready, out_valid}, 2'b10);

    // Busy: a second request in T+3 must be ignored.
    in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; a = 8'hF0; b = 8'hF0; cin = 1'b1;
    check("busy_in_ready", in_ready, 0);
    @(negedge clk); in_valid = 1'b0;
    lat = 4;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_latency", lat, W + 1);
    check("busy_result", {cout, sum}, 9'h046);
    @(negedge clk);

    // Abort: reset in T+4, no result afterwards.
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", {in_ready, out_valid}, 2'b10);
    check("abort_cleared", {cout, sum, a_out, b_out, carry}, 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    // Random operations with random idle gaps and downstream stalls.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = $urandom; rb = $urandom; rc = $urandom;
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(ra, rb, rc, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (!out_valid || {cout, sum} !== exp9) begin
        errors++;
        $display("FAIL rand%0d: %0h+%0h+%0h got valid=%0d %0h want %0h", n, ra, rb, rc,
                 out_valid, {cout, sum}, exp9);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
